// File: rtl/contador_programa.sv
// Next-PC sequencing stage: selects the next program counter from the ALU
// flags, the decoded targets and the current opcode. It also stalls on IN,
// swaps between kernel and user mode, stops on HALT and counts retired
// instructions. All outputs come straight from registers.
module contador_programa #(
  parameter int unsigned        LARG_PC     = 32,
  parameter logic [LARG_PC-1:0] PC_INICIAL  = '0,
  parameter logic [LARG_PC-1:0] BASE_KERNEL = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic [LARG_PC-1:0] Resultado,
  input  logic [LARG_PC-1:0] Alvo_Desvio,
  input  logic [LARG_PC-1:0] Alvo_Registro,
  input  logic               Entrada_Pronta,
  input  logic               Pausa,
  output logic [LARG_PC-1:0] PC,
  output logic [LARG_PC-1:0] PC_Retorno,
  output logic               Modo_Kernel,
  output logic               Aguardando,
  output logic               Parado,
  output logic [31:0]        Instrucoes
);

  localparam logic [5:0] OP_JUMP = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_JR   = 6'b010011;
  localparam logic [5:0] OP_IN   = 6'b001000;
  localparam logic [5:0] OP_SWAP = 6'b100001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    ESPERA_IN = 2'd1,
    PARADO    = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARG_PC-1:0] pc_q, pc_d;
  logic [LARG_PC-1:0] ret_q, ret_d;
  logic               kernel_q, kernel_d;
  logic               aguard_q, aguard_d;
  logic               parado_q, parado_d;
  logic [31:0]        instr_q, instr_d;
  logic [LARG_PC-1:0] pc_mais1;

  // PC+1 wraps naturally at the register width
  assign pc_mais1 = pc_q + 1'b1;

  // State register: asynchronous reset, otherwise load the next-state values
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= EXEC;
      pc_q     <= PC_INICIAL;
      ret_q    <= '0;
      kernel_q <= 1'b0;
      aguard_q <= 1'b0;
      parado_q <= 1'b0;
      instr_q  <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      ret_q    <= ret_d;
      kernel_q <= kernel_d;
      aguard_q <= aguard_d;
      parado_q <= parado_d;
      instr_q  <= instr_d;
    end
  end

  // Next-state decision: hold everything by default; a stall or PARADO keeps the defaults
  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    ret_d    = ret_q;
    kernel_d = kernel_q;
    aguard_d = aguard_q;
    parado_d = parado_q;
    instr_d  = instr_q;
    if (!Pausa) begin
      unique case (estado_q)
        EXEC: begin
          instr_d = instr_q + 32'd1;
          unique case (Opcode)
            OP_JUMP: pc_d = Zero ? Resultado : pc_mais1;
            OP_BEQ,
            OP_BNE:  pc_d = Zero ? Alvo_Desvio : pc_mais1;
            OP_JR:   pc_d = Zero ? Alvo_Registro : pc_mais1;
            OP_IN: begin
              if (Entrada_Pronta) begin
                pc_d = pc_mais1;
              end else begin
                // A blocked IN does not retire until the input arrives
                instr_d  = instr_q;
                aguard_d = 1'b1;
                estado_d = ESPERA_IN;
              end
            end
            OP_SWAP: begin
              if (kernel_q) begin
                pc_d     = Resultado;
                kernel_d = 1'b0;
              end else begin
                ret_d    = pc_mais1;
                pc_d     = BASE_KERNEL;
                kernel_d = 1'b1;
              end
            end
            OP_HALT: begin
              parado_d = 1'b1;
              estado_d = PARADO;
            end
            default: pc_d = pc_mais1;
          endcase
        end
        ESPERA_IN: begin
          if (Entrada_Pronta) begin
            pc_d     = pc_mais1;
            aguard_d = 1'b0;
            instr_d  = instr_q + 32'd1;
            estado_d = EXEC;
          end
        end
        PARADO: begin
          estado_d = PARADO;
        end
        default: estado_d = EXEC;
      endcase
    end
  end

  assign PC          = pc_q;
  assign PC_Retorno  = ret_q;
  assign Modo_Kernel = kernel_q;
  assign Aguardando  = aguard_q;
  assign Parado      = parado_q;
  assign Instrucoes  = instr_q;

endmodule

// File: doc/contador_programa.md
Name: contador_programa

Overview:
- Next-PC / fetch-sequencing stage directly downstream of the ALU.
- Consumes the ALU's `Zero` flag and `Resultado`, together with the current `Opcode`, and decides the program counter for the next cycle.
- Holds the processor while waiting on user input (IN). Handles kernel/user swaps for the OS and HALT. Keeps a retired-instruction counter.
- Drives the instruction-memory address.

Parameters:
- LARG_PC, 32, width of PC, PC_Retorno and all targets.
- PC_INICIAL, 0, PC value loaded on reset.
- BASE_KERNEL, 0, PC loaded on entry to kernel mode.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  opcode of the instruction currently executing.
- Zero  in  1  ALU branch/jump-taken flag.
- Resultado  in  LARG_PC  ALU result; jump target for JUMP and kernel-exit.
- Alvo_Desvio  in  LARG_PC  branch target from decode (BEQ/BNE).
- Alvo_Registro  in  LARG_PC  register-sourced target (JR).
- Entrada_Pronta  in  1  user input valid (IN handshake).
- Pausa  in  1  global stall; freezes all state.
- PC  out  LARG_PC  current instruction address.
- PC_Retorno  out  LARG_PC  saved user PC on kernel entry.
- Modo_Kernel  out  1  1 = executing kernel code.
- Aguardando  out  1  1 = stalled on IN.
- Parado  out  1  1 = HALT reached.
- Instrucoes  out  32  retired-instruction count.

Behaviour:
- Reset (asynchronous, active-high; overrides everything, including mid-wait):
  - PC = PC_INICIAL; PC_Retorno = 0; Modo_Kernel = 0.
  - Aguardando = 0; Parado = 0; Instrucoes = 0.
  - State = EXEC.
- Pausa = 1 (when reset is low): no register changes in any state; Entrada_Pronta is ignored.
- FSM states: EXEC, ESPERA_IN, PARADO. Each entry below gives the state or opcode, the required action, and the resulting state.
- EXEC, one instruction retired per cycle, Instrucoes += 1:
  - JUMP 000101: if Zero, PC <= Resultado; else PC <= PC+1.
  - BEQ 001010 / BNE 001011: if Zero, PC <= Alvo_Desvio; else PC <= PC+1.
  - JR 010011: if Zero, PC <= Alvo_Registro; else PC <= PC+1.
  - IN 001000:
    - If Entrada_Pronta = 1 in the same cycle, PC <= PC+1 and stay in EXEC.
    - Otherwise PC is held, Aguardando <= 1, next state ESPERA_IN, and Instrucoes is not incremented.
  - Swap Kernel 100001, Modo_Kernel = 0: PC_Retorno <= PC+1; PC <= BASE_KERNEL; Modo_Kernel <= 1.
  - Swap Kernel 100001, Modo_Kernel = 1: PC <= Resultado; Modo_Kernel <= 0; PC_Retorno unchanged.
  - HALT 111111: PC held; Parado <= 1; next state PARADO; Instrucoes += 1.
  - All other opcodes, including undefined ones: PC <= PC+1.
- ESPERA_IN:
  - PC held while waiting.
  - On Entrada_Pronta = 1: PC <= PC+1, Aguardando <= 0, Instrucoes += 1, next state EXEC.
  - Opcode, Zero and targets are ignored while waiting.
- PARADO: all state frozen; only reset exits.
- Arithmetic:
  - PC+1 wraps modulo 2^LARG_PC (all-ones -> 0, no flag).
  - Instrucoes wraps modulo 2^32.
  - Targets are used unmodified (word addressing).
- Latency: every PC update is visible the cycle after the decision edge. All outputs are registered.

Test Plan:
- Reset, then ten cycles of Opcode=000000 -> PC = 0,1,…,10; Instrucoes = 10; Modo_Kernel = 0.
- PC=5, Opcode=001010:
  - Zero=1, Alvo_Desvio=0x40 -> PC = 0x40.
  - Repeat with Zero=0 -> PC = 6.
  - Opcode=000101, Zero=1, Resultado=0x80 -> PC = 0x80.
- PC=7, Opcode=001000, Entrada_Pronta=0:
  - Aguardando = 1 and PC stays 7 for three cycles with Instrucoes frozen.
  - Entrada_Pronta=1 -> PC = 8, Aguardando = 0, Instrucoes +1.
  - Same opcode with Entrada_Pronta=1 in the first cycle -> PC = 8 with no wait.
- PC=0x20, user mode, Opcode=100001 (BASE_KERNEL=0) -> PC = 0, PC_Retorno = 0x21, Modo_Kernel = 1.
  - Then Opcode=100001 with Resultado=0x21 -> PC = 0x21, Modo_Kernel = 0.
- PC=0xFFFFFFFF, Opcode=000000 -> PC = 0. Opcode=111111 -> Parado = 1 and PC frozen for 5 cycles.
- Stall/reset interaction:
  - Pausa=1 during ESPERA_IN with Entrada_Pronta=1 -> no change.
  - Asynchronous reset asserted mid-ESPERA_IN, between clock edges -> PC = PC_INICIAL, Aguardando = 0 immediately.
